fact_accel_mmio: RTL and testbench

Parametrised memory-mapped factorial accelerator: a 4-word register window holding operand, control, status and result, plus an iterative multiply FSM that computes n! one multiply per clock. It is the next generation of the factorial SoC peripheral. Over the previous generation it adds:
- configurable operand and result widths;
- a busy flag;
- overflow detection;
- write-1-to-clear status;
- a level interrupt.

It sits on the CPU data bus behind the SoC address decoder, which supplies word-index `A` and `WE`.

---
 rtl/fact_accel_mmio_if.sv | 18 +
 rtl/fact_accel_mmio.sv | 137 +++++++++++++
 tb/tb_fact_accel_mmio.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fact_accel_mmio_if.sv
// ---------------------------------------------------------------------------
// fact_accel_mmio_if : CPU-side register-window bus of the factorial engine
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fact_accel_mmio_if;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        Irq;

  modport master (output A, output WE, output WD, input RD, input Irq);
  modport slave  (input A, input WE, input WD, output RD, output Irq);
endinterface

`default_nettype wire

// File: rtl/fact_accel_mmio.sv
// ---------------------------------------------------------------------------
// fact_accel_mmio : memory-mapped n! accelerator, one multiply per clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fact_accel_mmio #(
  parameter int DATA_W = 32,
  parameter int N_W    = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  fact_accel_mmio_if.slave bus
);

  localparam int P_W = DATA_W + N_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [N_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                go_q, go_d;
  logic                ie_q, ie_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                wr_n, wr_ctrl, wr_status, start;
  logic [P_W-1:0]      prod;
  logic                prod_ovf;
  logic [31:0]         rd;

  always_comb begin
    wr_n      = bus.WE && (bus.A == 2'd0);
    wr_ctrl   = bus.WE && (bus.A == 2'd1);
    wr_status = bus.WE && (bus.A == 2'd2);
    start     = wr_ctrl && bus.WD[0] && (state_q == IDLE);
    prod      = P_W'(acc_q) * P_W'(cnt_q);
    prod_ovf  = (prod[P_W-1:DATA_W] != '0);
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    go_d     = go_q;
    ie_d     = ie_q;
    done_d   = done_q;
    err_d    = err_q;

    if (wr_n) begin
      n_d = bus.WD[N_W-1:0];
    end
    if (wr_ctrl) begin
      go_d = bus.WD[0];
      ie_d = bus.WD[1];
    end
    if (wr_status) begin
      if (bus.WD[0]) done_d = 1'b0;
      if (bus.WD[1]) err_d  = 1'b0;
    end

    // Flag sets come after the W1C so a finish on the same edge wins.
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = DATA_W'(1);
          cnt_d   = n_q;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q <= N_W'(1)) begin
          result_d = acc_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (prod_ovf) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          acc_d = prod[DATA_W-1:0];
          cnt_d = cnt_q - N_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      go_q     <= 1'b0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      go_q     <= go_d;
      ie_q     <= ie_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    rd = '0;
    case (bus.A)
      2'd0:    rd[N_W-1:0]    = n_q;
      2'd1:    rd[1:0]        = {ie_q, go_q};
      2'd2:    rd[2:0]        = {(state_q == CALC), err_q, done_q};
      default: rd[DATA_W-1:0] = result_q;
    endcase
  end

  assign bus.RD  = rd;
  assign bus.Irq = ie_q & (done_q | err_q);

endmodule

`default_nettype wire

// File: tb/tb_fact_accel_mmio.sv
// ---------------------------------------------------------------------------
// tb_fact_accel_mmio : three parameterisations driven in lockstep, checked
// against an arithmetic factorial model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fact_accel_mmio;

  logic        Clk;
  logic        Rst;
  logic        clk_en;
  logic [1:0]  a_drv;
  logic        we_drv;
  logic [31:0] wd_drv;

  int n_tests;
  int n_fail;

  int          dw [3];
  int          nw [3];
  logic [31:0] exp_res [3];
  logic [31:0] rd_w [3];
  logic        irq_w [3];

  fact_accel_mmio_if if0 ();
  fact_accel_mmio_if if1 ();
  fact_accel_mmio_if if2 ();

  assign if0.A = a_drv;  assign if0.WE = we_drv;  assign if0.WD = wd_drv;
  assign if1.A = a_drv;  assign if1.WE = we_drv;  assign if1.WD = wd_drv;
  assign if2.A = a_drv;  assign if2.WE = we_drv;  assign if2.WD = wd_drv;

  assign rd_w[0] = if0.RD;  assign irq_w[0] = if0.Irq;
  assign rd_w[1] = if1.RD;  assign irq_w[1] = if1.Irq;
  assign rd_w[2] = if2.RD;  assign irq_w[2] = if2.Irq;

  fact_accel_mmio #(.DATA_W(32), .N_W(4)) u_dut0 (.Clk(Clk), .Rst(Rst), .bus(if0));
  fact_accel_mmio #(.DATA_W(16), .N_W(3)) u_dut1 (.Clk(Clk), .Rst(Rst), .bus(if1));
  fact_accel_mmio #(.DATA_W(8),  .N_W(4)) u_dut2 (.Clk(Clk), .Rst(Rst), .bus(if2));

  initial Clk = 1'b0;
  always #5 if (clk_en) Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: n! by plain arithmetic, reporting which clock the engine finishes on.
  function automatic void model(input int n, input int w, output bit err,
                                output int cyc, output longint res);
    longint acc;
    acc = 1;
    err = 1'b0;
    cyc = (n < 1) ? 1 : n;
    for (int m = n; m >= 2; m--) begin
      acc = acc * m;
      if (acc >= (longint'(1) << w)) begin
        err = 1'b1;
        cyc = n - m + 1;
        break;
      end
    end
    res = acc;
  endfunction

  task automatic set_a(input logic [1:0] a);
    a_drv = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    a_drv  = a;
    we_drv = 1'b1;
    wd_drv = d;
    @(posedge Clk);
    @(negedge Clk);
    we_drv = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      set_a(2'(a));
      for (int d = 0; d < 3; d++)
        check($sformatf("%s d%0d rd a%0d", tag, d, a), rd_w[d], 32'd0);
    end
    for (int d = 0; d < 3; d++)
      check($sformatf("%s d%0d irq", tag, d), {31'd0, irq_w[d]}, 32'd0);
  endtask

  task automatic run(input int n, input bit ie);
    int          nd [3];
    bit          er [3];
    int          cy [3];
    longint      rs [3];
    int          mx;
    logic [31:0] es;
    mx = 0;
    for (int d = 0; d < 3; d++) begin
      nd[d] = n % (1 << nw[d]);
      model(nd[d], dw[d], er[d], cy[d], rs[d]);
      if (cy[d] > mx) mx = cy[d];
    end
    wr(2'd0, 32'(n));
    wr(2'd1, {30'd0, ie, 1'b1});
    for (int j = 0; j <= mx; j++) begin
      set_a(2'd2);
      for (int d = 0; d < 3; d++) begin
        es = {29'd0, (j < cy[d]), ((j >= cy[d]) && er[d]), ((j >= cy[d]) && !er[d])};
        check($sformatf("n%0d d%0d status j%0d", n, d, j), rd_w[d], es);
        check($sformatf("n%0d d%0d irq j%0d", n, d, j), {31'd0, irq_w[d]},
              {31'd0, (ie && (j >= cy[d]))});
      end
      @(negedge Clk);
    end
    set_a(2'd3);
    for (int d = 0; d < 3; d++) begin
      if (!er[d]) exp_res[d] = rs[d][31:0];
      check($sformatf("n%0d d%0d result", n, d), rd_w[d], exp_res[d]);
    end
    set_a(2'd0);
    for (int d = 0; d < 3; d++)
      check($sformatf("n%0d d%0d nread", n, d), rd_w[d], 32'(nd[d]));
    set_a(2'd1);
    for (int d = 0; d < 3; d++)
      check($sformatf("n%0d d%0d ctrl", n, d), rd_w[d], {30'd0, ie, 1'b1});
    wr(2'd2, 32'd3);
    set_a(2'd2);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("n%0d d%0d w1c status", n, d), rd_w[d], 32'd0);
      check($sformatf("n%0d d%0d w1c irq", n, d), {31'd0, irq_w[d]}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fixed_n [8];
    n_tests = 0;
    n_fail  = 0;
    dw = '{32, 16, 8};
    nw = '{4, 3, 4};
    fixed_n = '{5, 0, 1, 12, 13, 15, 7, 6};
    for (int d = 0; d < 3; d++) exp_res[d] = 32'd0;
    clk_en = 1'b0;
    Rst    = 1'b0;
    a_drv  = 2'd0;
    we_drv = 1'b0;
    wd_drv = 32'd0;

    // Asynchronous reset with the clock stopped.
    #2 Rst = 1'b1;
    check_all_zero("reset");
    clk_en = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    wr(2'd0, 32'd5);
    set_a(2'd0);
    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d n readback", d), rd_w[d], 32'd5);

    for (int i = 0; i < 8; i++) run(fixed_n[i], 1'b1);
    for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // W1C of Done on the very edge that sets it: all three finish n=5 at k+5.
    wr(2'd0, 32'd5);
    wr(2'd1, 32'd3);
    for (int j = 0; j < 4; j++) begin
      set_a(2'd2);
      for (int d = 0; d < 3; d++)
        check($sformatf("coll d%0d busy j%0d", d, j), rd_w[d], 32'd4);
      @(negedge Clk);
    end
    wr(2'd2, 32'd1);
    set_a(2'd2);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("coll d%0d done wins", d), rd_w[d], 32'd1);
      check($sformatf("coll d%0d irq", d), {31'd0, irq_w[d]}, 32'd1);
    end
    set_a(2'd3);
    for (int d = 0; d < 3; d++) begin
      exp_res[d] = 32'd120;
      check($sformatf("coll d%0d result", d), rd_w[d], 32'd120);
    end
    wr(2'd2, 32'd3);

    // Writes during a run; only the 32-bit instance is meaningful here.
    wr(2'd0, 32'd10);
    wr(2'd1, 32'd1);
    @(negedge Clk);
    @(negedge Clk);
    wr(2'd0, 32'd3);
    set_a(2'd0);
    check("midwr n readback", rd_w[0], 32'd3);
    wr(2'd1, 32'd1);
    for (int j = 4; j <= 10; j++) begin
      set_a(2'd2);
      check($sformatf("midwr status j%0d", j), rd_w[0],
            {29'd0, (j < 10), 1'b0, (j >= 10)});
      @(negedge Clk);
    end
    set_a(2'd3);
    check("midwr result", rd_w[0], 32'd3628800);

    // Reset in the middle of an n=9 run.
    wr(2'd0, 32'd9);
    wr(2'd1, 32'd3);
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst = 1'b1;
    check_all_zero("midrst");
    for (int j = 0; j < 10; j++) @(negedge Clk);
    check_all_zero("midrst hold");
    @(negedge Clk);
    Rst = 1'b0;
    for (int d = 0; d < 3; d++) exp_res[d] = 32'd0;
    run(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
